qs_fifo_ext: RTL and testbench
==============================

Name: qs_fifo_ext

Overview:
Parametrised synchronous FIFO. It is the next generation of the basic qs_fifo and adds the following:
- programmable almost-full and almost-empty thresholds
- an occupancy count
- a selectable read mode: registered, or first-word-fall-through (FWFT)
- a synchronous flush
- sticky overflow and underflow error flags

It is used as the general-purpose single-clock buffer between producer and consumer pipelines in one clock domain.

Parameters:
DATA_W, 8, data width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
AF_LEVEL, DEPTH-2, almost_full_o asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty_o asserts when count <= AE_LEVEL (0..DEPTH-1)
FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through

Ports:
clk  in  1  clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
clear_i  in  1  synchronous flush: empties the FIFO and clears the error flags
push_i  in  1  write request
push_data_i  in  DATA_W  write data
pop_i  in  1  read request
pop_data_o  out  DATA_W  read data
pop_valid_o  out  1  pop_data_o is valid
full_o  out  1  count == DEPTH
empty_o  out  1  count == 0
almost_full_o  out  1  count >= AF_LEVEL
almost_empty_o  out  1  count <= AE_LEVEL
count_o  out  $clog2(DEPTH)+1  current occupancy
overflow_o  out  1  sticky: a push was dropped
underflow_o  out  1  sticky: a pop was made while empty

Behaviour:
- Reset (synchronous, highest priority):
  - Pointers and count go to 0.
  - Outputs after reset: empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=0, count_o=0, pop_data_o=0, pop_valid_o=0, overflow_o=0, underflow_o=0.
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all stored data; the next cycle looks exactly like post-reset.
- clear_i (priority below reset, above push/pop): same effect as reset on pointers, count, flags and pop_valid_o. Any push or pop in that cycle is ignored and is not flagged as an error.
- Pointers: $clog2(DEPTH) bits wide; they wrap naturally from DEPTH-1 to 0.
- Count: count_o is a registered counter. +1 on accepted push only, -1 on accepted pop only, unchanged if both or neither are accepted.
- Flags: full_o, empty_o, almost_full_o and almost_empty_o are derived from the registered count only, never from same-cycle requests. They reflect an operation on the cycle after the edge that performs it.
- Accepted pop: pop_i && !empty_o.
- Accepted push: push_i && (!full_o || pop_i).
  - When full, a simultaneous pop and push are both accepted and count stays at DEPTH.
  - When empty, a simultaneous pop and push: the push is accepted, the pop is rejected, and underflow_o is set.
- Push with full_o=1 and pop_i=0: data is dropped; overflow_o sets and holds until reset or clear_i.
- Pop with empty_o=1: no pointer change, pop_data_o holds its value, underflow_o sets (sticky).
- FWFT=0 (registered read):
  - On an accepted pop, pop_data_o is loaded with the head entry at that edge, and pop_valid_o is 1 for the following cycle only.
  - Otherwise pop_valid_o=0 and pop_data_o holds its last value.
  - Latency: pop_i at edge N gives data valid after edge N.
- FWFT=1 (first-word-fall-through):
  - pop_data_o = the head entry whenever !empty_o; pop_valid_o = !empty_o.
  - pop_i acts as an acknowledge and advances to the next entry.
  - Write-to-read latency: a push at edge N into an empty FIFO makes the data visible after edge N (count becomes 1).
- Elaboration checks (generate-time $error):
  - DEPTH not a power of two or < 2
  - AF_LEVEL outside 1..DEPTH
  - AE_LEVEL outside 0..DEPTH-1

Decomposition:
- Shared package qs_fifo_pkg holds:
  - the function qs_cnt_w(depth) = $clog2(depth)+1
  - the read-mode constants QS_RD_REG=0 and QS_RD_FWFT=1
- Sub-module qs_fifo_mem:
  - a DEPTH x DATA_W storage array
  - synchronous write port and asynchronous read port, indexed by the pointers
  - allows a later swap to an SRAM macro
- Control, pointers, count and flags stay in qs_fifo_ext.

Test Plan:
Unless stated otherwise, all scenarios use DATA_W=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2, FWFT=0.
1. Fill then drain:
   - Reset, then push 16 random bytes → full_o=1, count_o=16; almost_full_o first asserts after the 14th push.
   - Pop 16 → data returned in order, each valid one cycle after its pop; then empty_o=1, almost_empty_o=1, underflow_o=0.
2. Overflow:
   - When full, push 0xAA with pop_i=0 → count_o stays 16, overflow_o=1 and sticky.
   - The drained data contains no 0xAA.
   - clear_i → overflow_o=0, count_o=0.
3. Underflow: pop on empty after reset → underflow_o=1, pop_valid_o=0, pop_data_o stays 0x00, pointers unchanged.
4. Simultaneous push/pop:
   - At count=16, push+pop together → count stays 16 and the head is popped.
   - At count=0, push 0x5C + pop → count=1, underflow_o=1, and a later pop returns 0x5C.
5. Wrap-around and mid-run reset:
   - Run 40 push/pop cycles at occupancy about 5 → data order preserved across pointer wrap.
   - Assert reset with count=7 → next cycle count_o=0, empty_o=1, all flags at reset values.
6. FWFT=1:
   - Push 0x11 at edge N → after edge N, pop_valid_o=1 and pop_data_o=0x11 with no pop.
   - Then push 0x22 and pop once → pop_data_o=0x22.
   - Pop again → pop_valid_o=0.

Source files
------------

// File: rtl/qs_fifo_pkg.sv
// Shared definitions for the qs_fifo family: counter width helper and read-mode encodings.
package qs_fifo_pkg;

  typedef enum int unsigned {
    QS_RD_REG  = 0,
    QS_RD_FWFT = 1
  } qs_rd_mode_e;

  function automatic int qs_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/qs_fifo_mem.sv
// FIFO storage: synchronous write, asynchronous read; kept separate so it can be swapped for an SRAM macro.
module qs_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/qs_fifo_ext.sv
// Single-clock FIFO with thresholds, occupancy count, registered or FWFT read, flush and sticky error flags.
module qs_fifo_ext
  import qs_fifo_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear_i,
  input  logic                        push_i,
  input  logic [DATA_W-1:0]           push_data_i,
  input  logic                        pop_i,
  output logic [DATA_W-1:0]           pop_data_o,
  output logic                        pop_valid_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic                        almost_full_o,
  output logic                        almost_empty_o,
  output logic [qs_cnt_w(DEPTH)-1:0]  count_o,
  output logic                        overflow_o,
  output logic                        underflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = qs_cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C   = CNT_W'(AE_LEVEL);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("qs_fifo_ext: DEPTH must be a power of two and >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
      $error("qs_fifo_ext: AF_LEVEL must lie in 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
      $error("qs_fifo_ext: AE_LEVEL must lie in 0..DEPTH-1");
    end
    if (FWFT != int'(QS_RD_REG) && FWFT != int'(QS_RD_FWFT)) begin : g_bad_mode
      $error("qs_fifo_ext: FWFT must be 0 or 1");
    end
  endgenerate

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] head;
  logic              full;
  logic              empty;
  logic              push_acc;
  logic              pop_acc;
  logic              overflow_q;
  logic              underflow_q;

  // Flags come from the registered count only, never from this cycle's requests.
  always_comb begin
    full     = (count == FULL_C);
    empty    = (count == '0);
    pop_acc  = pop_i && !empty;
    push_acc = push_i && (!full || pop_i);
  end

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_acc, pop_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_i && full && !pop_i) overflow_q  <= 1'b1;
      if (pop_i && empty)           underflow_q <= 1'b1;
    end
  end

  qs_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push_acc && !reset && !clear_i),
    .wr_addr (wr_ptr),
    .wr_data (push_data_i),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  generate
    if (FWFT == int'(QS_RD_FWFT)) begin : g_fwft
      // Head entry is presented combinationally; zero while empty so reset state reads 0.
      assign pop_data_o  = empty ? '0 : head;
      assign pop_valid_o = !empty;
    end else begin : g_reg
      logic [DATA_W-1:0] data_q;
      logic              valid_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else if (clear_i) begin
          valid_q <= 1'b0;
        end else begin
          valid_q <= pop_acc;
          if (pop_acc) data_q <= head;
        end
      end

      assign pop_data_o  = data_q;
      assign pop_valid_o = valid_q;
    end
  endgenerate

  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = (count >= AF_C);
  assign almost_empty_o = (count <= AE_C);
  assign count_o        = count;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_qs_fifo_ext.sv
// Directed bench for qs_fifo_ext: registered-read instance (a_*) and FWFT instance (b_*).
module tb_qs_fifo_ext;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic       a_clear = 0, a_push = 0, a_pop = 0;
  logic [7:0] a_wdata = '0, a_rdata;
  logic       a_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [4:0] a_count;

  logic       b_clear = 0, b_push = 0, b_pop = 0;
  logic [7:0] b_wdata = '0, b_rdata;
  logic       b_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [4:0] b_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qs_fifo_ext #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) dut_a (
    .clk(clk), .reset(reset), .clear_i(a_clear), .push_i(a_push), .push_data_i(a_wdata),
    .pop_i(a_pop), .pop_data_o(a_rdata), .pop_valid_o(a_valid), .full_o(a_full),
    .empty_o(a_empty), .almost_full_o(a_af), .almost_empty_o(a_ae), .count_o(a_count),
    .overflow_o(a_ovf), .underflow_o(a_unf)
  );

  qs_fifo_ext #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) dut_b (
    .clk(clk), .reset(reset), .clear_i(b_clear), .push_i(b_push), .push_data_i(b_wdata),
    .pop_i(b_pop), .pop_data_o(b_rdata), .pop_valid_o(b_valid), .full_o(b_full),
    .empty_o(b_empty), .almost_full_o(b_af), .almost_empty_o(b_ae), .count_o(b_count),
    .overflow_o(b_ovf), .underflow_o(b_unf)
  );

  function automatic logic [7:0] fd(input int i);
    return 8'(i * 37 + 5);
  endfunction

  function automatic logic [7:0] wv(input int k);
    return 8'(k * 7 + 1);
  endfunction

  task automatic step_a(input logic push, input logic [7:0] d, input logic pop);
    a_push = push; a_wdata = d; a_pop = pop;
    @(posedge clk); #1;
    a_push = 0; a_pop = 0; a_clear = 0;
  endtask

  task automatic step_b(input logic push, input logic [7:0] d, input logic pop);
    b_push = push; b_wdata = d; b_pop = pop;
    @(posedge clk); #1;
    b_push = 0; b_pop = 0; b_clear = 0;
  endtask

  task automatic clear_a();
    a_clear = 1;
    step_a(1'b1, 8'h99, 1'b1);
    checks++;
    if ({a_count, a_empty, a_ovf, a_unf, a_valid} !== {5'd0, 4'b1000}) begin
      errors++;
      $display("FAIL clear_a: cnt/empty/ovf/unf/valid got %b expected %b",
               {a_count, a_empty, a_ovf, a_unf, a_valid}, {5'd0, 4'b1000});
    end
  endtask

  task automatic test_reset();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    checks++;
    if ({a_empty, a_full, a_ae, a_af, a_valid, a_ovf, a_unf} !== 7'b1010000) begin
      errors++;
      $display("FAIL reset_a_flags: got %b expected %b",
               {a_empty, a_full, a_ae, a_af, a_valid, a_ovf, a_unf}, 7'b1010000);
    end
    checks++;
    if (a_count !== 5'd0 || a_rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_a_count_data: got count %0d data %h expected 0 00", a_count, a_rdata);
    end
    checks++;
    if ({b_empty, b_full, b_ae, b_af, b_valid, b_ovf, b_unf} !== 7'b1010000 ||
        b_count !== 5'd0 || b_rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_b: flags %b count %0d data %h expected 1010000 0 00",
               {b_empty, b_full, b_ae, b_af, b_valid, b_ovf, b_unf}, b_count, b_rdata);
    end
  endtask

  task automatic test_underflow();
    step_a(1'b0, 8'h00, 1'b1);
    checks++;
    if ({a_unf, a_valid, a_empty} !== 3'b101 || a_rdata !== 8'h00 || a_count !== 5'd0) begin
      errors++;
      $display("FAIL underflow: unf/valid/empty %b data %h count %0d expected 101 00 0",
               {a_unf, a_valid, a_empty}, a_rdata, a_count);
    end
    step_a(1'b1, 8'h33, 1'b0);
    step_a(1'b0, 8'h00, 1'b1);
    checks++;
    if (a_rdata !== 8'h33 || a_valid !== 1'b1 || a_unf !== 1'b1) begin
      errors++;
      $display("FAIL underflow_ptr: data %h valid %b unf %b expected 33 1 1", a_rdata, a_valid, a_unf);
    end
    clear_a();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      step_a(1'b1, fd(i), 1'b0);
      checks++;
      if (a_count !== 5'(i + 1) || a_af !== 1'(i + 1 >= 14)) begin
        errors++;
        $display("FAIL fill_%0d: count %0d af %b expected %0d %b", i, a_count, a_af, i + 1, 1'(i + 1 >= 14));
      end
    end
    checks++;
    if (a_full !== 1'b1) begin
      errors++;
      $display("FAIL fill_full: got %b expected 1", a_full);
    end
    for (int i = 0; i < 16; i++) begin
      step_a(1'b0, 8'h00, 1'b1);
      checks++;
      if (a_valid !== 1'b1 || a_rdata !== fd(i) || a_count !== 5'(15 - i)) begin
        errors++;
        $display("FAIL drain_%0d: valid %b data %h count %0d expected 1 %h %0d",
                 i, a_valid, a_rdata, a_count, fd(i), 15 - i);
      end
    end
    step_a(1'b0, 8'h00, 1'b0);
    checks++;
    if ({a_valid, a_empty, a_ae, a_full, a_unf} !== 5'b01100) begin
      errors++;
      $display("FAIL drain_end: valid/empty/ae/full/unf %b expected 01100",
               {a_valid, a_empty, a_ae, a_full, a_unf});
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) step_a(1'b1, 8'(8'h40 + i), 1'b0);
    step_a(1'b1, 8'hAA, 1'b0);
    checks++;
    if (a_count !== 5'd16 || a_ovf !== 1'b1 || a_full !== 1'b1) begin
      errors++;
      $display("FAIL overflow: count %0d ovf %b full %b expected 16 1 1", a_count, a_ovf, a_full);
    end
    step_a(1'b0, 8'h00, 1'b0);
    checks++;
    if (a_ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got %b expected 1", a_ovf);
    end
    for (int i = 0; i < 16; i++) begin
      step_a(1'b0, 8'h00, 1'b1);
      checks++;
      if (a_rdata !== 8'(8'h40 + i) || a_valid !== 1'b1) begin
        errors++;
        $display("FAIL overflow_drain_%0d: data %h valid %b expected %h 1", i, a_rdata, a_valid, 8'(8'h40 + i));
      end
    end
    checks++;
    if (a_ovf !== 1'b1 || a_unf !== 1'b0 || a_empty !== 1'b1) begin
      errors++;
      $display("FAIL overflow_after_drain: ovf %b unf %b empty %b expected 1 0 1", a_ovf, a_unf, a_empty);
    end
    clear_a();
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 16; i++) step_a(1'b1, 8'(8'h60 + i), 1'b0);
    step_a(1'b1, 8'h77, 1'b1);
    checks++;
    if (a_count !== 5'd16 || a_full !== 1'b1 || a_valid !== 1'b1 || a_rdata !== 8'h60 || a_ovf !== 1'b0) begin
      errors++;
      $display("FAIL simul_full: count %0d full %b valid %b data %h ovf %b expected 16 1 1 60 0",
               a_count, a_full, a_valid, a_rdata, a_ovf);
    end
    for (int i = 0; i < 16; i++) begin
      step_a(1'b0, 8'h00, 1'b1);
      checks++;
      if (a_rdata !== ((i == 15) ? 8'h77 : 8'(8'h61 + i))) begin
        errors++;
        $display("FAIL simul_drain_%0d: data %h expected %h", i, a_rdata, (i == 15) ? 8'h77 : 8'(8'h61 + i));
      end
    end
    step_a(1'b1, 8'h5C, 1'b1);
    checks++;
    if (a_count !== 5'd1 || a_unf !== 1'b1 || a_valid !== 1'b0) begin
      errors++;
      $display("FAIL simul_empty: count %0d unf %b valid %b expected 1 1 0", a_count, a_unf, a_valid);
    end
    step_a(1'b0, 8'h00, 1'b1);
    checks++;
    if (a_rdata !== 8'h5C || a_valid !== 1'b1 || a_count !== 5'd0) begin
      errors++;
      $display("FAIL simul_empty_pop: data %h valid %b count %0d expected 5c 1 0", a_rdata, a_valid, a_count);
    end
    clear_a();
  endtask

  task automatic test_wrap_and_reset();
    for (int k = 0; k < 5; k++) step_a(1'b1, wv(k), 1'b0);
    for (int i = 0; i < 40; i++) begin
      step_a(1'b1, wv(5 + i), 1'b1);
      checks++;
      if (a_rdata !== wv(i) || a_count !== 5'd5 || a_valid !== 1'b1) begin
        errors++;
        $display("FAIL wrap_%0d: data %h count %0d valid %b expected %h 5 1", i, a_rdata, a_count, a_valid, wv(i));
      end
    end
    step_a(1'b1, wv(45), 1'b0);
    step_a(1'b1, wv(46), 1'b0);
    checks++;
    if (a_count !== 5'd7) begin
      errors++;
      $display("FAIL pre_reset_count: got %0d expected 7", a_count);
    end
    reset = 1; a_push = 1; a_wdata = 8'hEE;
    @(posedge clk); #1;
    reset = 0; a_push = 0;
    checks++;
    if ({a_empty, a_full, a_ae, a_af, a_valid, a_ovf, a_unf} !== 7'b1010000 ||
        a_count !== 5'd0 || a_rdata !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: flags %b count %0d data %h expected 1010000 0 00",
               {a_empty, a_full, a_ae, a_af, a_valid, a_ovf, a_unf}, a_count, a_rdata);
    end
  endtask

  task automatic test_fwft();
    step_b(1'b1, 8'h11, 1'b0);
    checks++;
    if (b_valid !== 1'b1 || b_rdata !== 8'h11 || b_count !== 5'd1) begin
      errors++;
      $display("FAIL fwft_first: valid %b data %h count %0d expected 1 11 1", b_valid, b_rdata, b_count);
    end
    step_b(1'b1, 8'h22, 1'b1);
    checks++;
    if (b_valid !== 1'b1 || b_rdata !== 8'h22 || b_count !== 5'd1) begin
      errors++;
      $display("FAIL fwft_second: valid %b data %h count %0d expected 1 22 1", b_valid, b_rdata, b_count);
    end
    step_b(1'b0, 8'h00, 1'b1);
    checks++;
    if (b_valid !== 1'b0 || b_empty !== 1'b1 || b_unf !== 1'b0) begin
      errors++;
      $display("FAIL fwft_drained: valid %b empty %b unf %b expected 0 1 0", b_valid, b_empty, b_unf);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run time exceeded limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_underflow();
    test_fill_drain();
    test_overflow();
    test_simultaneous();
    test_wrap_and_reset();
    test_fwft();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
